// File: rtl/i2c_slave_regif_pkg.sv
// Shared definitions for the I2C register-interface target.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_slave_regif_pkg;

  // Default 7-bit target address (MPU9150 with AD0 low).
  localparam logic [6:0] DEV_ADDR_MPU9150 = 7'h68;

  // SDA level seen during the acknowledge bit.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser + glitch filter + edge detector for one I2C line.
// Latency: 2 sync flops + FILT_LEN agreement + 1 output flop after a pin change.
// Backpressure: none; pulses are single-cycle and never held.
// Ports: clk_i/rst_ni clock and async active-low reset; line_i raw pin;
//        level_o filtered level; rise_o/fall_o one-cycle pulses aligned with level_o.
module i2c_line_filter #(
  parameter int FILT_LEN = 3  // must be >= 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0]          sync_q;
  logic [FILT_LEN-1:0] hist_q;
  logic                level_q;
  logic                level_d;
  logic                rise_q;
  logic                fall_q;

  // The filtered level only moves once every stored sample agrees; anything
  // shorter than FILT_LEN cycles leaves it untouched.
  always_comb begin
    level_d = level_q;
    if (&hist_q) begin
      level_d = 1'b1;
    end else if (~|hist_q) begin
      level_d = 1'b0;
    end
  end

  // Reset to the idle-bus level (high) so release of reset never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      hist_q  <= '1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      hist_q  <= {hist_q[FILT_LEN-2:0], sync_q[1]};
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target exposing a 2**ADDR_W register space on a parallel write/read port.
// Latency: Wr_En 1 CLK after the filtered 8th-bit SCL rise; Rd_Dat latched on SCL fall.
// Backpressure: none; no clock stretching, the bank must keep up (Rd_Dat <= 2 CLK).
// Ports: CLK/RSTn clock and async active-low reset; SCL/SDA I2C pins (SDA open-drain);
//        Wr_En/Wr_Addr/Wr_Dat write strobe; Rd_Addr/Rd_Dat/Rd_Strobe read side; Busy.
module i2c_slave_regif
  import i2c_slave_regif_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_MPU9150,
  parameter int         ADDR_W   = 7,
  parameter int         FILT_LEN = 3
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [7:0]        Wr_Dat,
  output logic [ADDR_W-1:0] Rd_Addr,
  input  logic [7:0]        Rd_Dat,
  output logic              Rd_Strobe,
  output logic              Busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_i  (CLK),
    .rst_ni (RSTn),
    .line_i (SCL),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_i  (CLK),
    .rst_ni (RSTn),
    .line_i (SDA),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic start_ev, stop_ev;
  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  i2c_state_e        state_q, state_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        rx_q, rx_d;      // first 7 bits of the byte being received
  logic [6:0]        tx_q, tx_d;      // bits still to send; MSB goes straight from Rd_Dat
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_dat_q, wr_dat_d;
  logic              rd_strobe_q, rd_strobe_d;

  logic [7:0] rx_byte;
  assign rx_byte = {rx_q, sda_lvl};

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_dat_d    = wr_dat_q;
    rd_strobe_d = 1'b0;

    // Bus events beat any bit sample in the same cycle; partial bytes are dropped.
    if (start_ev) begin
      state_d  = ST_ADDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_ev) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            rx_d     = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              if (state_q == ST_ADDR) begin
                // General call (all-zero address) is never acknowledged.
                if (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != 7'd0) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_REG) begin
                ptr_d   = rx_byte[ADDR_W-1:0];
                state_d = ST_REG_ACK;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_dat_d  = rx_byte;
                ptr_d     = ptr_q + ADDR_W'(1);
                state_d   = ST_WDATA_ACK;
              end
            end
          end
        end

        // ACK is driven from the first SCL fall to the second; sda_oe_q
        // doubles as the phase flag since SDA is released on entry.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                tx_d        = Rd_Dat[6:0];
                rd_strobe_d = 1'b1;
                sda_oe_d    = (Rd_Dat[7] != I2C_NACK);
                state_d     = ST_RDATA;
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_REG;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        // bitcnt counts master sampling rises; the fall after the 8th frees SDA.
        ST_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q != 4'd0) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = ST_RDATA_ACK;
            end else begin
              tx_d     = {tx_q[5:0], 1'b0};
              sda_oe_d = (tx_q[6] != I2C_NACK);
            end
          end
        end

        // bitcnt==1 marks "master acknowledged, load next byte on the fall".
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (sda_lvl == I2C_ACK) begin
              bitcnt_d = 4'd1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else if (scl_fall && bitcnt_q == 4'd1) begin
            tx_d        = Rd_Dat[6:0];
            rd_strobe_d = 1'b1;
            sda_oe_d    = (Rd_Dat[7] != I2C_NACK);
            bitcnt_d    = 4'd0;
            state_d     = ST_RDATA;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 4'd0;
      rx_q        <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_dat_q    <= '0;
      rd_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_dat_q    <= wr_dat_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  assign SDA       = sda_oe_q ? 1'b0 : 1'bz;
  assign Wr_En     = wr_en_q;
  assign Wr_Addr   = wr_addr_q;
  assign Wr_Dat    = wr_dat_q;
  assign Rd_Addr   = ptr_q;
  assign Rd_Strobe = rd_strobe_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Self-checking bench: bit-banged I2C master, bank model returning {0,addr},
// and a pointer/write-log reference model.
module tb_i2c_slave_regif;

  localparam int Q = 31;  // quarter SCL period in CLK cycles (~400 kHz at 50 MHz)

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       SCL = 1'b1;
  logic       m_oe = 1'b0;
  wire        SDA;
  logic       Wr_En;
  logic [6:0] Wr_Addr;
  logic [7:0] Wr_Dat;
  logic [6:0] Rd_Addr;
  logic [7:0] Rd_Dat;
  logic       Rd_Strobe;
  logic       Busy;

  always #10 CLK = ~CLK;

  assign SDA = m_oe ? 1'b0 : 1'bz;
  pullup (SDA);
  assign Rd_Dat = {1'b0, Rd_Addr};

  i2c_slave_regif dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .SCL      (SCL),
    .SDA      (SDA),
    .Wr_En    (Wr_En),
    .Wr_Addr  (Wr_Addr),
    .Wr_Dat   (Wr_Dat),
    .Rd_Addr  (Rd_Addr),
    .Rd_Dat   (Rd_Dat),
    .Rd_Strobe(Rd_Strobe),
    .Busy     (Busy)
  );

  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  int          dut_low_cnt = 0;
  int          m_ptr = 0;
  logic [15:0] wr_log[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  tx_data[$];

  always @(negedge CLK) begin
    if (Wr_En) wr_log.push_back({1'b0, Wr_Addr, Wr_Dat});
    if (Rd_Strobe) strobe_cnt++;
    if (!m_oe && SDA === 1'b0) dut_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_start();
    m_oe = 1'b1;
    wclk(Q);
    SCL = 1'b0;
  endtask

  task automatic bus_rstart();
    wclk(Q); m_oe = 1'b0;
    wclk(Q); SCL = 1'b1;
    wclk(Q); m_oe = 1'b1;
    wclk(Q); SCL = 1'b0;
  endtask

  task automatic bus_stop();
    wclk(Q); m_oe = 1'b1;
    wclk(Q); SCL = 1'b1;
    wclk(Q); m_oe = 1'b0;
    wclk(Q);
  endtask

  // One bit slot starting with SCL low; optional 1-CLK SCL glitch in the low phase.
  task automatic bus_bit(input bit b, input bit glitch, output bit s);
    wclk(Q);
    m_oe = ~b;
    if (glitch) begin
      wclk(8); SCL = 1'b1;
      wclk(1); SCL = 1'b0;
      wclk(Q - 9);
    end else begin
      wclk(Q);
    end
    SCL = 1'b1;
    wclk(Q);
    s = SDA;
    wclk(Q);
    SCL = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int glitch_bit, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], (i == glitch_bit), s);
    bus_bit(1'b1, 1'b0, s);
    ack = (s == 1'b0);
  endtask

  task automatic recv_byte(input bit master_ack, output logic [7:0] d);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    bus_bit(master_ack ? 1'b0 : 1'b1, 1'b0, s);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) check(tag, wr_log[i], exp_wr[i]);
    wr_log.delete();
    exp_wr.delete();
  endtask

  // Write transaction: pointer byte reg_a, then the bytes queued in tx_data.
  task automatic do_write(input int reg_a, input int gl_byte, input int gl_bit);
    bit ack;
    bus_start();
    send_byte(8'hD0, -1, ack);
    check("wr_dev_ack", ack, 1);
    check("busy_after_match", Busy, 1);
    send_byte(8'(reg_a), -1, ack);
    check("wr_ptr_ack", ack, 1);
    m_ptr = reg_a % 128;
    for (int i = 0; i < tx_data.size(); i++) begin
      send_byte(tx_data[i], (i == gl_byte) ? gl_bit : -1, ack);
      check("wr_data_ack", ack, 1);
      exp_wr.push_back({1'b0, 7'(m_ptr), tx_data[i]});
      m_ptr = (m_ptr + 1) % 128;
    end
    bus_stop();
    wclk(4);
    check("busy_after_stop", Busy, 0);
    check("ptr_after_wr", Rd_Addr, m_ptr);
    check_writes("wr_log");
  endtask

  // Read n bytes, optionally setting the pointer first via write + repeated START.
  task automatic do_read(input bit set_ptr, input int reg_a, input int n);
    bit ack;
    logic [7:0] d;
    int s0;
    bus_start();
    if (set_ptr) begin
      send_byte(8'hD0, -1, ack);
      check("rd_wdev_ack", ack, 1);
      send_byte(8'(reg_a), -1, ack);
      check("rd_ptr_ack", ack, 1);
      m_ptr = reg_a % 128;
      bus_rstart();
    end
    send_byte(8'hD1, -1, ack);
    check("rd_dev_ack", ack, 1);
    s0 = strobe_cnt;
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, d);
      check("rd_byte", d, m_ptr);
      m_ptr = (m_ptr + 1) % 128;
    end
    check("rd_strobes", strobe_cnt - s0, n);
    wclk(8);
    check("rd_sda_released", SDA, 1);
    bus_stop();
    wclk(4);
    check("rd_busy_after_stop", Busy, 0);
    check("ptr_after_rd", Rd_Addr, m_ptr);
    check_writes("rd_no_writes");
  endtask

  initial begin
    bit ack;
    int low0;

    // Reset state
    wclk(5);
    check("rst_sda", SDA, 1);
    check("rst_wr_en", Wr_En, 0);
    check("rst_wr_addr", Wr_Addr, 0);
    check("rst_wr_dat", Wr_Dat, 0);
    check("rst_rd_addr", Rd_Addr, 0);
    check("rst_rd_strobe", Rd_Strobe, 0);
    check("rst_busy", Busy, 0);
    RSTn = 1'b1;
    wclk(20);

    // 1: single register write
    tx_data = '{8'h18};
    do_write(8'h1B, -1, -1);

    // 2: pointer set then 6-byte burst read
    do_read(1'b1, 8'h3B, 6);

    // 3: wrong address is ignored entirely
    low0 = dut_low_cnt;
    bus_start();
    send_byte(8'hD2, -1, ack);
    check("wrong_addr_nack", ack, 0);
    send_byte(8'h00, -1, ack);
    check("wrong_data_nack", ack, 0);
    check("wrong_busy", Busy, 0);
    bus_stop();
    wclk(4);
    check("wrong_sda_never_low", dut_low_cnt - low0, 0);
    check_writes("wrong_no_writes");

    // 4: STOP after 4 data bits discards the byte, then a clean write
    bus_start();
    send_byte(8'hD0, -1, ack);
    check("abort_dev_ack", ack, 1);
    send_byte(8'h10, -1, ack);
    check("abort_ptr_ack", ack, 1);
    m_ptr = 8'h10;
    for (int i = 0; i < 4; i++) bus_bit(i[0], 1'b0, ack);
    bus_stop();
    wclk(4);
    check("abort_busy", Busy, 0);
    check("abort_ptr_kept", Rd_Addr, m_ptr);
    check_writes("abort_no_writes");
    tx_data = '{8'h55};
    do_write(8'h10, -1, -1);

    // 5: pointer wrap 0x7F -> 0x00
    tx_data = '{8'hAA, 8'hBB};
    do_write(8'h7F, -1, -1);

    // 6a: 1-CLK SCL glitch inside a data byte
    tx_data = '{8'hC3};
    do_write(8'h22, 0, 4);

    // 6b: reset while the target is driving a 0 data bit
    bus_start();
    send_byte(8'hD1, -1, ack);
    check("rst_rd_dev_ack", ack, 1);
    wclk(12);
    check("rst_rd_driving_low", SDA, 0);
    RSTn = 1'b0;
    #1;
    check("rst_async_sda_release", SDA, 1);
    check("rst_async_busy", Busy, 0);
    check("rst_async_ptr", Rd_Addr, 0);
    wclk(3);
    SCL = 1'b1;
    m_oe = 1'b0;
    wclk(5);
    RSTn = 1'b1;
    m_ptr = 0;
    wclk(20);
    check_writes("rst_no_writes");
    tx_data = '{8'h77};
    do_write(8'h05, -1, -1);

    // Randomised transactions against the pointer/bank model
    for (int t = 0; t < 5; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        tx_data.delete();
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) tx_data.push_back(8'($urandom));
        do_write(int'($urandom_range(0, 255)), -1, -1);
      end else begin
        do_read(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
